blockmem_reader: RTL and testbench
==================================

Name: blockmem_reader

Overview:
- Read-side master for the synchronous 256x32 block memory.
- On a start command it streams a contiguous run of words from the memory's read port into a valid/ready output stream, and marks the last word.
- Absorbs the memory's one-cycle read latency with a 2-entry output buffer, so there is no word loss under backpressure.
- Sits between operand storage and the modexp datapath/operand loaders.

Parameters:
- ADDR_WIDTH, 8, memory word-address width (256 words)
- DATA_WIDTH, 32, memory and stream word width
- LEN_WIDTH, 9, length field width (ADDR_WIDTH+1, allows 0..256 words)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, captured on start
- length  in  LEN_WIDTH  number of words to stream, captured on start
- busy  out  1  high from the cycle after an accepted start until the done pulse
- done  out  1  one-cycle pulse when the run is complete
- rd  out  1  memory read enable
- read_addr  out  ADDR_WIDTH  memory read address
- read_data  in  DATA_WIDTH  memory read data, valid the cycle after rd
- out_valid  out  1  stream word valid
- out_ready  in  1  stream consumer ready
- out_data  out  DATA_WIDTH  stream word
- out_last  out  1  high with the final word of the run

Behaviour:
- Reset (async, reset_n low):
  - FSM goes to IDLE.
  - Buffer, in-flight flag and counters are cleared.
  - Outputs: busy=0, done=0, rd=0, read_addr=0, out_valid=0, out_data=0, out_last=0.
  - Reset mid-run abandons the run and emits no done.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 latches base_addr and length, clears the issue counter, goes to READ. If length=0, goes to DONE instead.
  - READ: issues reads. After the read with index length-1 has been issued, goes to DRAIN.
  - DRAIN: waits until the in-flight flag is 0 and the buffer is empty (the last word has been handshaken), then goes to DONE.
  - DONE: done=1 for exactly one cycle, then goes to IDLE. busy=0 in DONE.
- start outside IDLE is ignored; no queuing.
- Address generation:
  - read_addr = base_addr + issue_idx, modulo 2^ADDR_WIDTH.
  - Wrap from 0xFF to 0x00 is silent and legal.
  - read_addr holds its last value when rd=0.
- Issue rule:
  - rd=1 in READ when (buf_count + inflight) < 2, or when a stream pop (out_valid && out_ready) occurs this cycle.
  - Never issue beyond length words.
- In-flight flag: set on the edge where rd=1; cleared on the next edge, when read_data is written into the buffer.
- Buffer:
  - 2-entry FIFO on the output side.
  - A push and a pop in the same cycle are legal; count stays the same.
  - Overflow is impossible by the issue rule. The bench asserts this.
- Stream rules:
  - out_data is driven from the buffer head register.
  - Once out_valid rises, out_data and out_last are stable until the handshake.
  - A handshake occurs when out_valid && out_ready at a rising edge.
- out_last: each buffer entry carries a last tag, set when that entry's issue index equals length-1.
- Latency (start high in cycle T, out_ready high throughout):
  - T+1: rd=1.
  - T+2: read_data valid.
  - T+3: out_valid=1.
  - Sustained rate is 1 word/cycle.
  - done asserts in the cycle after the last handshake.
- length=0: no rd and no stream words; done is high in cycle T+1.
- length>=2^ADDR_WIDTH: addresses keep wrapping. A length of 256 reads every word exactly once.

Decomposition:
- Shared package/header holds:
  - FSM state encodings CTRL_IDLE, CTRL_READ, CTRL_DRAIN, CTRL_DONE.
  - The default widths: ADDR_WIDTH, DATA_WIDTH and LEN_WIDTH.
- One natural sub-module: blockmem_reader_fifo.
  - 2-entry data+last FIFO with push, pop, count, head outputs.
- The FSM, counter and issue logic stay in the top module.

Test Plan:
- Basic run:
  - Stimulus: memory preloaded mem[i]=0xA5000000+i; base=0x10, length=4, out_ready=1.
  - Required response: rd on T+1..T+4 with addr 0x10..0x13. out_data 0xA5000010..0xA5000013 on T+3..T+6. out_last only with 0xA5000013. done at T+7.
- Wrap:
  - Stimulus: base=0xFE, length=4.
  - Required response: read_addr FE, FF, 00, 01. Words mem[FE], mem[FF], mem[00], mem[01] in order.
- Backpressure:
  - Stimulus: length=16; out_ready pseudo-random, 50% duty.
  - Required response: all 16 words in order, none dropped or duplicated. Never more than 2 buffer entries plus in-flight. out_data stable while out_valid && !out_ready.
- Zero length, busy-ignore and full range:
  - Stimulus: length=0. Then a second start pulsed while busy. Then length=256 from base 0x80.
  - Required response:
    - length=0: no rd, done at T+1, no out_valid.
    - Start while busy: ignored.
    - length=256: exactly 256 words, with the address sequence wrapping at 0xFF.
- Reset mid-run:
  - Stimulus: reset_n pulled low after 3 words of a length=8 run.
  - Required response: all outputs 0 immediately. No done. A fresh start afterwards behaves as in the basic run.

Source files
------------

// File: rtl/blockmem_reader_pkg.sv
// Shared widths and controller state encoding for the block-memory read master.
package blockmem_reader_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 9;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_READ  = 2'd1,
        CTRL_DRAIN = 2'd2,
        CTRL_DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/blockmem_reader_fifo.sv
// Two-entry shift FIFO carrying a data word and its last tag; entry 0 is the head.
module blockmem_reader_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_head_last
);

    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_last0;
    logic                  r_last1;
    logic [1:0]            r_count;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= i_push_data;
                        r_last0 <= i_push_last;
                    end else begin
                        r_data1 <= i_push_data;
                        r_last1 <= i_push_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new word lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_data0 <= i_push_data;
                        r_last0 <= i_push_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= i_push_data;
                        r_last1 <= i_push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_valid     = (r_count != 2'd0);
    assign o_head_data = r_data0;
    assign o_head_last = r_last0;

endmodule

// File: rtl/blockmem_reader.sv
// Streams a contiguous run of block-memory words onto a valid/ready port, tagging the last word.
module blockmem_reader
    import blockmem_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = blockmem_reader_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = blockmem_reader_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = blockmem_reader_pkg::LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  rd,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output ctrl_state_t           dbg_state
);

    ctrl_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issue_idx;
    logic                  r_inflight;
    logic                  r_infl_last;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_busy;
    logic                  r_done;

    logic [1:0]            w_count;
    logic                  w_head_valid;
    logic                  w_head_last;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_issue;
    logic                  w_issue_last;
    logic [ADDR_WIDTH-1:0] w_issue_addr;

    // Stream handshake: a word moves on a rising edge where out_valid && out_ready;
    // out_valid never drops and out_data/out_last never change while waiting for ready.
    assign w_pop        = w_head_valid && out_ready;
    assign w_room       = (({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2);
    assign w_issue      = (r_state == CTRL_READ) && (r_issue_idx < r_len) && (w_room || w_pop);
    assign w_issue_last = (r_issue_idx == (r_len - LEN_WIDTH'(1)));
    assign w_issue_addr = r_base + r_issue_idx[ADDR_WIDTH-1:0];

    blockmem_reader_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (r_inflight),
        .i_push_data (read_data),
        .i_push_last (r_infl_last),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_valid     (w_head_valid),
        .o_head_data (out_data),
        .o_head_last (w_head_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= CTRL_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_issue_idx <= '0;
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
            r_last_addr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight  <= w_issue;
            r_infl_last <= w_issue && w_issue_last;
            if (w_issue) begin
                r_issue_idx <= r_issue_idx + LEN_WIDTH'(1);
                r_last_addr <= w_issue_addr;
            end
            case (r_state)
                CTRL_IDLE: begin
                    if (start) begin
                        r_base      <= base_addr;
                        r_len       <= length;
                        r_issue_idx <= '0;
                        if (length == '0) begin
                            r_state <= CTRL_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= CTRL_READ;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                CTRL_READ: begin
                    if (w_issue && w_issue_last) r_state <= CTRL_DRAIN;
                end
                CTRL_DRAIN: begin
                    // Leave as the final word is handshaken so done lands one cycle later.
                    if (!r_inflight && ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop))) begin
                        r_state <= CTRL_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                CTRL_DONE: begin
                    r_state <= CTRL_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= CTRL_IDLE;
            endcase
        end
    end

    assign rd        = w_issue;
    assign read_addr = w_issue ? w_issue_addr : r_last_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = w_head_valid;
    assign out_last  = w_head_last && w_head_valid;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_blockmem_reader.sv
// Directed bench for blockmem_reader with a registered memory model and stream monitor.
module tb_blockmem_reader;
    import blockmem_reader_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [8:0]  length = 9'd0;
    logic        busy;
    logic        done;
    logic        rd;
    logic [7:0]  read_addr;
    logic [31:0] read_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    ctrl_state_t dbg_state;

    blockmem_reader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rd        (rd),
        .read_addr (read_addr),
        .read_data (read_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .dbg_state (dbg_state)
    );

    // clock / reset / memory model
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [256];
    always @(posedge clk) if (rd) read_data <= mem[read_addr];

    // scoreboard state
    int total = 0;
    int bad = 0;
    logic [7:0]  addr_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] data_q[$];
    logic        last_q[$];
    int rd_cyc_first;
    int data_cyc_first;
    int done_cyc;
    int done_cnt;
    logic busy_at_done;
    int outstanding = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        addr_q.delete();
        exp_q.delete();
        data_q.delete();
        last_q.delete();
        rd_cyc_first   = -1;
        data_cyc_first = -1;
        done_cyc       = -1;
        done_cnt       = 0;
        busy_at_done   = 1'bx;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("occupancy_le_2", {31'd0, (outstanding <= 2)}, 32'd1);
            if (prev_stall) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, prev_data);
                check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (rd) begin
                if (addr_q.size() == 0) rd_cyc_first = cyc;
                addr_q.push_back(read_addr);
            end
            if (out_valid && out_ready) begin
                if (data_q.size() == 0) data_cyc_first = cyc;
                data_q.push_back(out_data);
                last_q.push_back(out_last);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            outstanding = outstanding + (rd ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
            prev_last   = out_last;
        end else begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_rd"}, {31'd0, rd}, 32'd0);
        check({tag, "_addr"}, {24'd0, read_addr}, 32'd0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, CTRL_IDLE});
    endtask

    // driver: one run, optional random backpressure, optional ignored second start
    task automatic run(input string tag, input logic [7:0] b, input int len,
                       input bit rnd, input bit ign);
        int t0;
        int n;
        int lim;
        logic [7:0] ea;
        clear_mon();
        for (int i = 0; i < len; i++) begin
            ea = b + 8'(i);
            exp_q.push_back(32'hA500_0000 + {24'd0, ea});
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = 9'(len); t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'h00; length = 9'd0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check({tag, "_busy_t1"}, {31'd0, busy}, {31'd0, (len != 0)});
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (ign && n == 2) begin
                start = 1'b1; base_addr = 8'h50; length = 9'd7;
            end else begin
                start = 1'b0; base_addr = 8'h00; length = 9'd0;
            end
        end
        check({tag, "_done_seen"}, {31'd0, (done_cnt != 0)}, 32'd1);
        out_ready = 1'b1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
        check({tag, "_n_rd"}, 32'(addr_q.size()), 32'(len));
        check({tag, "_n_words"}, 32'(data_q.size()), 32'(len));
        lim = (data_q.size() < len) ? data_q.size() : len;
        for (int i = 0; i < lim && i < addr_q.size(); i++) begin
            ea = b + 8'(i);
            check({tag, "_addr"}, {24'd0, addr_q[i]}, {24'd0, ea});
            check({tag, "_data"}, data_q[i], exp_q[i]);
            check({tag, "_last"}, {31'd0, last_q[i]}, {31'd0, (i == len - 1)});
        end
        if (!rnd) begin
            if (len > 0) begin
                check({tag, "_rd_lat"}, 32'(rd_cyc_first), 32'(t0 + 1));
                check({tag, "_data_lat"}, 32'(data_cyc_first), 32'(t0 + 3));
                check({tag, "_done_lat"}, 32'(done_cyc), 32'(t0 + len + 3));
            end else begin
                check({tag, "_done_lat"}, 32'(done_cyc), 32'(t0 + 1));
            end
        end
        check({tag, "_idle"}, {30'd0, dbg_state}, {30'd0, CTRL_IDLE});
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run("basic", 8'h10, 4, 1'b0, 1'b0);
        run("wrap", 8'hFE, 4, 1'b0, 1'b0);
        run("bp", 8'h40, 16, 1'b1, 1'b0);
        run("bp_wrap", 8'hF8, 16, 1'b1, 1'b0);
        run("zero", 8'h33, 0, 1'b0, 1'b0);
        run("ignore", 8'h20, 4, 1'b0, 1'b1);
        run("full", 8'h80, 256, 1'b0, 1'b0);

        // reset in the middle of an 8-word run
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h30; length = 9'd8;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'h00; length = 9'd0;
        n = 0;
        while (data_q.size() < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_three_words", 32'(data_q.size()), 32'd3);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_no_rd", {31'd0, rd}, 32'd0);
        run("after_rst", 8'h10, 4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
